// File: rtl/pq_sorted_array.sv
// Sorted-array priority queue: DEPTH entries {id, prio}, head at index 0.
// Push/pop in IDLE, drop-by-id through a two-cycle search/done sequence.
module pq_sorted_array #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IW        = 4,
  parameter int unsigned PW        = 3,
  parameter int unsigned MAX_FIRST = 1,
  parameter int unsigned EVICT     = 0,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [IW-1:0] push_id_i,
  input  logic [PW-1:0] push_prio_i,
  output logic          push_rdy_o,
  input  logic          pop_i,
  output logic          pop_rdy_o,
  output logic          pop_vld_o,
  output logic [IW-1:0] pop_id_o,
  output logic [PW-1:0] pop_prio_o,
  input  logic          drop_i,
  input  logic [IW-1:0] drop_id_i,
  output logic          drop_rdy_o,
  output logic          drop_vld_o,
  output logic          drop_hit_o,
  output logic          evict_vld_o,
  output logic [IW-1:0] evict_id_o,
  output logic          peek_vld_o,
  output logic [IW-1:0] peek_id_o,
  output logic [PW-1:0] peek_prio_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  typedef enum logic [1:0] {S_IDLE, S_DROP_SRCH, S_DROP_DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] id_q      [DEPTH];
  logic [PW-1:0] prio_q    [DEPTH];
  logic [IW-1:0] id_d      [DEPTH];
  logic [PW-1:0] prio_d    [DEPTH];
  logic [IW-1:0] base_id   [DEPTH];
  logic [PW-1:0] base_prio [DEPTH];
  logic [IW-1:0] drop_id_q;
  logic          hit_q;
  logic [CW-1:0] cnt;
  logic          drop_acc, push_acc, pop_acc, do_ins, do_evict, drop_found;
  logic [IW-1:0] evict_id_d;
  int unsigned   ins_k, drop_j;

  function automatic logic beats(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (MAX_FIRST != 0) ? (a > b) : (a < b);
  endfunction

  assign count_o     = cnt;
  assign full_o      = (cnt == CW'(DEPTH));
  assign empty_o     = (cnt == '0);
  assign peek_vld_o  = (id_q[0] != '0);
  assign peek_id_o   = id_q[0];
  assign peek_prio_o = prio_q[0];

  assign drop_acc = drop_i & drop_rdy_o;
  assign push_acc = push_i & push_rdy_o & ~drop_acc;
  assign pop_acc  = pop_i & pop_rdy_o & ~drop_acc;
  assign do_ins   = push_acc & (push_id_i != '0);
  assign do_evict = do_ins & full_o & ~pop_acc;

  // Occupancy: valid entries are those with a non-zero id
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) cnt = cnt + CW'(id_q[i] != '0);
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    push_rdy_o = 1'b0;
    pop_rdy_o  = 1'b0;
    drop_rdy_o = 1'b0;
    drop_vld_o = 1'b0;
    drop_hit_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        push_rdy_o = ~full_o | (EVICT != 0);
        pop_rdy_o  = ~empty_o;
        drop_rdy_o = 1'b1;
        if (drop_i) state_d = S_DROP_SRCH;
      end
      S_DROP_SRCH: state_d = S_DROP_DONE;
      S_DROP_DONE: begin
        drop_vld_o = 1'b1;
        drop_hit_o = hit_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array update: pop shifts up first, the push is then inserted into the
  // shifted view, so push+pop on a full queue never evicts
  always_comb begin
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      base_id[i]   = pop_acc ? id_q[i+1]   : id_q[i];
      base_prio[i] = pop_acc ? prio_q[i+1] : prio_q[i];
    end
    base_id[DEPTH-1]   = pop_acc ? '0 : id_q[DEPTH-1];
    base_prio[DEPTH-1] = pop_acc ? '0 : prio_q[DEPTH-1];

    ins_k = DEPTH;
    for (int unsigned i = DEPTH; i > 0; i--)
      if (base_id[i-1] == '0 || beats(push_prio_i, base_prio[i-1])) ins_k = i - 1;

    drop_j = DEPTH;
    for (int unsigned i = DEPTH; i > 0; i--)
      if (drop_id_q != '0 && id_q[i-1] == drop_id_q) drop_j = i - 1;
    drop_found = (drop_j < DEPTH);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      id_d[i]   = id_q[i];
      prio_d[i] = prio_q[i];
    end
    evict_id_d = (ins_k == DEPTH) ? push_id_i : id_q[DEPTH-1];

    if (state_q == S_DROP_SRCH) begin
      if (drop_found) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          if (i >= drop_j) begin
            id_d[i]   = id_q[i+1];
            prio_d[i] = prio_q[i+1];
          end
        end
        id_d[DEPTH-1]   = '0;
        prio_d[DEPTH-1] = '0;
      end
    end else if (pop_acc || do_ins) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        id_d[i]   = base_id[i];
        prio_d[i] = base_prio[i];
      end
      if (do_ins) begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
          if (i > ins_k) begin
            id_d[i]   = base_id[i-1];
            prio_d[i] = base_prio[i-1];
          end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i == ins_k) begin
            id_d[i]   = push_id_i;
            prio_d[i] = push_prio_i;
          end
        end
      end
    end
  end

  // Storage, drop bookkeeping and registered result pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        prio_q[i] <= '0;
      end
      drop_id_q   <= '0;
      hit_q       <= 1'b0;
      pop_vld_o   <= 1'b0;
      pop_id_o    <= '0;
      pop_prio_o  <= '0;
      evict_vld_o <= 1'b0;
      evict_id_o  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        id_q[i]   <= id_d[i];
        prio_q[i] <= prio_d[i];
      end
      if (drop_acc) drop_id_q <= drop_id_i;
      if (state_q == S_DROP_SRCH) hit_q <= drop_found;
      pop_vld_o   <= pop_acc;
      pop_id_o    <= pop_acc ? id_q[0] : '0;
      pop_prio_o  <= pop_acc ? prio_q[0] : '0;
      evict_vld_o <= do_evict;
      evict_id_o  <= do_evict ? evict_id_d : '0;
    end
  end

endmodule

// File: tb/tb_pq_sorted_array.sv
// Bench for pq_sorted_array: three DEPTH=4 instances (max-first reject,
// max-first evict, min-first reject) driven by shared stimulus and compared
// with a list-based reference model of the queue.
module tb_pq_sorted_array;

  logic       clk = 1'b0;
  logic       rst, push, pop, drop;
  logic [3:0] push_id, drop_id;
  logic [2:0] push_prio;

  logic       push_rdy [3], pop_rdy [3], drop_rdy [3], pop_vld [3], drop_vld [3];
  logic       drop_hit [3], evict_vld [3], peek_vld [3], full [3], empty [3];
  logic [3:0] pop_id [3], evict_id [3], peek_id [3];
  logic [2:0] pop_prio [3], peek_prio [3], count [3];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state per instance
  int mid [3][4];
  int mpr [3][4];
  int mn [3], mst [3], mdid [3];
  int epv [3], epid [3], eppr [3], edv [3], edh [3], eev [3], eeid [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pq_sorted_array #(
      .DEPTH(4), .IW(4), .PW(3),
      .MAX_FIRST((g == 2) ? 0 : 1),
      .EVICT((g == 1) ? 1 : 0)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .push_i(push), .push_id_i(push_id), .push_prio_i(push_prio), .push_rdy_o(push_rdy[g]),
      .pop_i(pop), .pop_rdy_o(pop_rdy[g]), .pop_vld_o(pop_vld[g]),
      .pop_id_o(pop_id[g]), .pop_prio_o(pop_prio[g]),
      .drop_i(drop), .drop_id_i(drop_id), .drop_rdy_o(drop_rdy[g]),
      .drop_vld_o(drop_vld[g]), .drop_hit_o(drop_hit[g]),
      .evict_vld_o(evict_vld[g]), .evict_id_o(evict_id[g]),
      .peek_vld_o(peek_vld[g]), .peek_id_o(peek_id[g]), .peek_prio_o(peek_prio[g]),
      .count_o(count[g]), .full_o(full[g]), .empty_o(empty[g])
    );
  end

  function automatic bit mf(input int m); return m != 2; endfunction
  function automatic bit ev(input int m); return m == 1; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_remove(input int m, input int j);
    for (int i = j; i < mn[m] - 1; i++) begin
      mid[m][i] = mid[m][i+1];
      mpr[m][i] = mpr[m][i+1];
    end
    mid[m][mn[m]-1] = 0;
    mpr[m][mn[m]-1] = 0;
    mn[m]--;
  endtask

  task automatic m_insert(input int m, input int id, input int pr);
    int k;
    k = mn[m];
    for (int i = mn[m] - 1; i >= 0; i--)
      if (mf(m) ? (pr > mpr[m][i]) : (pr < mpr[m][i])) k = i;
    if (mn[m] == 4) begin
      eev[m] = 1;
      if (k == 4) begin
        eeid[m] = id;
        return;
      end
      eeid[m] = mid[m][3];
      mn[m]   = 3;
    end
    for (int i = mn[m]; i > k; i--) begin
      mid[m][i] = mid[m][i-1];
      mpr[m][i] = mpr[m][i-1];
    end
    mid[m][k] = id;
    mpr[m][k] = pr;
    mn[m]++;
  endtask

  task automatic m_clear(input int m);
    for (int i = 0; i < 4; i++) begin
      mid[m][i] = 0;
      mpr[m][i] = 0;
    end
    mn[m] = 0; mst[m] = 0; mdid[m] = 0;
    epv[m] = 0; edv[m] = 0; eev[m] = 0;
  endtask

  task automatic m_update(input int m, input bit rs, input bit ps, input int pid, input int pp,
                          input bit po, input bit dr, input int did);
    int j;
    bit pa, pacc;
    epv[m] = 0; edv[m] = 0; eev[m] = 0;
    if (rs) begin
      m_clear(m);
    end else if (mst[m] == 1) begin
      j = -1;
      if (mdid[m] != 0)
        for (int i = mn[m] - 1; i >= 0; i--) if (mid[m][i] == mdid[m]) j = i;
      if (j >= 0) m_remove(m, j);
      mst[m] = 2; edv[m] = 1; edh[m] = (j >= 0);
    end else if (mst[m] == 2) begin
      mst[m] = 0;
    end else if (dr) begin
      mst[m] = 1; mdid[m] = did;
    end else begin
      pa   = ps && (mn[m] < 4 || ev(m));
      pacc = po && mn[m] > 0;
      if (pacc) begin
        epv[m] = 1; epid[m] = mid[m][0]; eppr[m] = mpr[m][0];
        m_remove(m, 0);
      end
      if (pa && pid != 0) m_insert(m, pid, pp);
    end
  endtask

  task automatic check_state();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("u%0d.count", m), count[m], mn[m]);
      chk($sformatf("u%0d.full", m), full[m], mn[m] == 4);
      chk($sformatf("u%0d.empty", m), empty[m], mn[m] == 0);
      chk($sformatf("u%0d.peek_vld", m), peek_vld[m], mn[m] > 0);
      chk($sformatf("u%0d.peek_id", m), peek_id[m], mid[m][0]);
      chk($sformatf("u%0d.peek_prio", m), peek_prio[m], mpr[m][0]);
      chk($sformatf("u%0d.pop_vld", m), pop_vld[m], epv[m]);
      if (epv[m] != 0) begin
        chk($sformatf("u%0d.pop_id", m), pop_id[m], epid[m]);
        chk($sformatf("u%0d.pop_prio", m), pop_prio[m], eppr[m]);
      end
      chk($sformatf("u%0d.drop_vld", m), drop_vld[m], edv[m]);
      if (edv[m] != 0) chk($sformatf("u%0d.drop_hit", m), drop_hit[m], edh[m]);
      chk($sformatf("u%0d.evict_vld", m), evict_vld[m], eev[m]);
      if (eev[m] != 0) chk($sformatf("u%0d.evict_id", m), evict_id[m], eeid[m]);
    end
  endtask

  task automatic step(input bit rs, input bit ps, input int pid, input int pp,
                      input bit po, input bit dr, input int did);
    rst = rs; push = ps; push_id = 4'(pid); push_prio = 3'(pp);
    pop = po; drop = dr; drop_id = 4'(did);
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("u%0d.push_rdy", m), push_rdy[m], mst[m] == 0 && (mn[m] < 4 || ev(m)));
      chk($sformatf("u%0d.pop_rdy", m), pop_rdy[m], mst[m] == 0 && mn[m] > 0);
      chk($sformatf("u%0d.drop_rdy", m), drop_rdy[m], mst[m] == 0);
    end
    for (int m = 0; m < 3; m++) m_update(m, rs, ps, pid, pp, po, dr, did);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle();                           step(0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic do_reset();                       step(1, 0, 0, 0, 0, 0, 0);   endtask
  task automatic do_push(input int id, input int p); step(0, 1, id, p, 0, 0, 0); endtask
  task automatic do_pop();                         step(0, 0, 0, 0, 1, 0, 0);   endtask
  task automatic do_drop(input int id);            step(0, 0, 0, 0, 0, 1, id);  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; drop = 1'b0;
    push_id = '0; push_prio = '0; drop_id = '0;
    for (int m = 0; m < 3; m++) m_clear(m);
    repeat (2) @(posedge clk);
    #1;
    check_state();

    // priority order with FIFO among equal priorities
    do_push(1, 2); do_push(2, 5); do_push(3, 5);
    chk("dir.peek_head", peek_id[0], 2);
    do_pop(); chk("dir.pop1", pop_id[0], 2);
    do_pop(); chk("dir.pop2", pop_id[0], 3);
    do_pop(); chk("dir.pop3", pop_id[0], 1);
    do_pop(); chk("dir.pop_empty", pop_vld[0], 0);

    // full queue: reject vs evict
    do_reset();
    do_push(1, 6); do_push(2, 5); do_push(3, 4); do_push(4, 3);
    chk("full.u0_full", full[0], 1);
    do_push(9, 1);
    chk("evict.new_vld", evict_vld[1], 1);
    chk("evict.new_id", evict_id[1], 9);
    do_push(8, 7);
    chk("evict.tail_id", evict_id[1], 4);
    chk("evict.head", peek_id[1], 8);
    step(0, 1, 5, 7, 1, 0, 0);
    chk("full.pop_head", pop_id[0], 1);
    chk("pushpop.peek", peek_id[1], 5);
    chk("pushpop.count", count[1], 4);
    chk("pushpop.no_evict", evict_vld[1], 0);

    // drop by id
    do_reset();
    do_push(1, 6); do_push(2, 5); do_push(3, 4); do_push(4, 3);
    do_drop(3);
    chk("drop.not_yet", drop_vld[0], 0);
    idle();
    chk("drop.vld", drop_vld[0], 1);
    chk("drop.hit", drop_hit[0], 1);
    chk("drop.count", count[0], 3);
    idle();
    do_drop(7); idle();
    chk("drop.miss_vld", drop_vld[0], 1);
    chk("drop.miss_hit", drop_hit[0], 0);
    idle();
    do_pop(); chk("drop.order1", pop_id[0], 1);
    do_pop(); chk("drop.order2", pop_id[0], 2);
    do_pop(); chk("drop.order3", pop_id[0], 4);

    // min-first ordering
    do_reset();
    do_push(1, 3); do_push(2, 1); do_push(3, 2);
    do_pop(); chk("min.pop1", pop_prio[2], 1);
    do_pop(); chk("min.pop2", pop_prio[2], 2);
    do_pop(); chk("min.pop3", pop_prio[2], 3);
    do_pop(); chk("min.pop_empty", pop_vld[2], 0);

    // reset during the drop search cycle
    do_push(1, 1); do_push(2, 2);
    do_drop(1);
    do_reset();
    chk("rstdrop.empty", empty[0], 1);
    chk("rstdrop.count", count[0], 0);
    idle();
    chk("rstdrop.no_vld", drop_vld[0], 0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      step($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
